// File: rtl/capture_buffer.sv
// capture_buffer: circular sample capture with post-trigger window and oldest-first valid/ready readout
module capture_buffer #(
   parameter int SAMPLE_WIDTH = 8,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    arm,
   input  logic                    run,
   input  logic [SAMPLE_WIDTH-1:0] dataIn,
   input  logic                    validIn,
   input  logic [DEPTH_LOG2-1:0]   postCount,
   output logic [SAMPLE_WIDTH-1:0] dataOut,
   output logic                    dataOutValid,
   input  logic                    dataOutReady,
   output logic                    busy,
   output logic                    triggered,
   output logic                    done
);
   typedef enum logic [1:0] {S_IDLE, S_FILL, S_POST, S_READ} state_t;
   state_t r_state, w_next;
   logic [SAMPLE_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
   logic [SAMPLE_WIDTH-1:0] r_mem_q, r_skid_data, r_out_data;
   logic [DEPTH_LOG2-1:0]   r_wr_ptr, r_rd_ptr, r_remaining;
   logic [DEPTH_LOG2:0]     r_count, r_fetch_left;
   logic                    r_pend, r_skid_valid, r_out_valid, r_busy, r_triggered, r_done;
   logic                    w_we, w_xfer, w_issue, w_read_end, w_out_free;
   logic [1:0]              w_occ;
   assign w_xfer = r_out_valid & dataOutReady;
   assign w_out_free = ~r_out_valid | dataOutReady;
   assign w_occ = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_pend);
   assign w_we = validIn & ~arm & ((r_state == S_FILL) | ((r_state == S_POST) & (r_remaining != '0)));
   assign w_issue = (r_state == S_READ) & ~arm & (r_fetch_left != '0) & ((w_occ - 2'(w_xfer)) < 2'd2);
   assign w_read_end = (r_state == S_READ) & (r_fetch_left == '0) & ~r_skid_valid & ~r_pend & w_out_free;
   assign dataOut = r_out_data;
   assign dataOutValid = r_out_valid;
   assign busy = r_busy;
   assign triggered = r_triggered;
   assign done = r_done;
   // state register
   always_ff @(posedge clock) begin
      r_state <= reset ? S_IDLE : w_next;
   end
   // next state: arm restarts from any state, otherwise fill -> post -> read -> idle
   always_comb begin
      w_next = r_state;
      if (arm)
         w_next = S_FILL;
      else if (r_state == S_FILL && run)
         w_next = S_POST;
      else if (r_state == S_POST && r_remaining == '0)
         w_next = S_READ;
      else if (w_read_end)
         w_next = S_IDLE;
   end
   // sample memory with one-cycle registered read for the readout prefetch
   always_ff @(posedge clock) begin
      if (w_we)
         r_mem[r_wr_ptr] <= dataIn;
      if (w_issue)
         r_mem_q <= r_mem[r_rd_ptr];
   end
   // write pointers, counters, readout pipeline (fetch -> skid -> output) and status flags
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count <= '0;
         r_fetch_left <= '0;
         r_remaining <= '0;
         r_pend <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_data <= '0;
         r_out_valid <= 1'b0;
         r_out_data <= '0;
         r_busy <= 1'b0;
         r_triggered <= 1'b0;
         r_done <= 1'b0;
      end else if (arm) begin
         r_wr_ptr <= '0;
         r_count <= '0;
         r_pend <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out_valid <= 1'b0;
         r_done <= 1'b0;
         r_busy <= 1'b1;
         r_triggered <= 1'b0;
      end else begin
         r_busy <= w_next != S_IDLE;
         r_triggered <= (w_next == S_POST) | (w_next == S_READ);
         if (w_we) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_count <= r_count + {{DEPTH_LOG2{1'b0}}, ~r_count[DEPTH_LOG2]};
         end
         if (r_state == S_FILL && run)
            r_remaining <= postCount;
         else if (w_we && r_state == S_POST)
            r_remaining <= r_remaining - 1'b1;
         if (r_state == S_POST && r_remaining == '0) begin
            r_rd_ptr <= r_wr_ptr - r_count[DEPTH_LOG2-1:0];
            r_fetch_left <= r_count;
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_fetch_left <= r_fetch_left - 1'b1;
         end
         r_pend <= w_issue;
         if (w_out_free) begin
            if (r_skid_valid) begin
               r_out_data <= r_skid_data;
               r_out_valid <= 1'b1;
               r_skid_valid <= r_pend;
               if (r_pend)
                  r_skid_data <= r_mem_q;
            end else begin
               r_out_valid <= r_pend;
               if (r_pend)
                  r_out_data <= r_mem_q;
            end
         end else if (r_pend) begin
            r_skid_valid <= 1'b1;
            r_skid_data <= r_mem_q;
         end
         if (w_read_end)
            r_done <= 1'b1;
      end
   end
endmodule

// File: tb/tb_capture_buffer.sv
// tb_capture_buffer: directed captures checked against a window model and a per-cycle readout scoreboard
module tb_capture_buffer;
   logic       clock = 1'b0, reset = 1'b1, arm = 1'b0, run = 1'b0, validIn = 1'b0, dataOutReady = 1'b0;
   logic [7:0] dataIn = '0;
   logic [3:0] postCount = '0;
   logic [7:0] dataOut;
   logic       dataOutValid, busy, triggered, done;
   int errors = 0, checks = 0, cyc = 0, rdy_mode = 0;
   int n_xfer = 0, first_word = 0, last_word = 0, first_cyc = 0, last_cyc = 0;
   int exp_q[$];
   bit hold = 0, chk_done = 0;
   logic [7:0] hold_data = '0;

   capture_buffer #(.SAMPLE_WIDTH(8), .DEPTH_LOG2(4)) dut (
      .clock(clock), .reset(reset), .arm(arm), .run(run), .dataIn(dataIn), .validIn(validIn),
      .postCount(postCount), .dataOut(dataOut), .dataOutValid(dataOutValid),
      .dataOutReady(dataOutReady), .busy(busy), .triggered(triggered), .done(done)
   );

   always #5 clock = ~clock;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      dataOutReady = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   // scoreboard: every accepted word must be the next one of the expected window, held words must stay put
   always @(negedge clock) begin
      cyc++;
      if (reset || arm) begin
         hold = 0;
         chk_done = 0;
      end else begin
         if (chk_done) begin
            chk(done && !dataOutValid, "done_after_last", {done, dataOutValid}, 2);
            chk_done = 0;
         end
         if (hold)
            chk(dataOutValid && dataOut == hold_data, "hold_stable", dataOutValid ? int'(dataOut) : -1, int'(hold_data));
         if (dataOutValid && dataOutReady) begin
            if (exp_q.size() == 0)
               chk(0, "extra_word", int'(dataOut), -1);
            else begin
               chk(int'(dataOut) == exp_q[0], "read_data", int'(dataOut), exp_q[0]);
               void'(exp_q.pop_front());
               if (n_xfer == 0) begin
                  first_word = int'(dataOut);
                  first_cyc = cyc;
               end
               last_word = int'(dataOut);
               last_cyc = cyc;
               n_xfer++;
               if (exp_q.size() == 0)
                  chk_done = 1;
            end
         end
         hold = dataOutValid && !dataOutReady;
         hold_data = dataOut;
      end
   end

   // one capture: sample k carries base+k, run rides on sample trig, gap-1 idle cycles precede each sample
   task automatic capture(input int post, input int trig, input int n, input int base, input int gap,
                          input int rmode, input int abort_at);
      int first;
      bit fin;
      first = trig + post - 15;
      if (first < 0)
         first = 0;
      exp_q.delete();
      for (int k = first; k <= trig + post; k++)
         exp_q.push_back((base + k) & 255);
      n_xfer = 0;
      rdy_mode = rmode;
      postCount = post[3:0];
      arm = 1'b1;
      validIn = 1'b1;
      dataIn = 8'hEE;
      run = 1'b0;
      tick();
      arm = 1'b0;
      chk(busy && !triggered && !done, "armed", {busy, triggered, done}, 4);
      for (int k = 0; k < n; k++) begin
         for (int g = 1; g < gap; g++) begin
            validIn = 1'b0;
            run = 1'b0;
            tick();
         end
         validIn = 1'b1;
         dataIn = 8'(base + k);
         run = (k == trig);
         tick();
         if (k == trig)
            chk(triggered && busy, "triggered", {triggered, busy}, 3);
      end
      validIn = 1'b0;
      run = 1'b0;
      fin = 0;
      for (int t = 0; t < 600 && !fin; t++) begin
         if (abort_at >= 0 && n_xfer >= abort_at) begin
            rdy_mode = 2;
            dataOutReady = 1'b0;
            exp_q.delete();
            arm = 1'b1;
            tick();
            arm = 1'b0;
            chk(!dataOutValid && busy && !triggered && !done, "arm_abort",
                {dataOutValid, busy, triggered, done}, 4);
            chk(n_xfer == abort_at, "abort_xfers", n_xfer, abort_at);
            return;
         end
         if (done)
            fin = 1;
         else
            tick();
      end
      chk(fin, "done_timeout", int'(fin), 1);
      chk(!busy && !triggered && !dataOutValid, "idle_after", {busy, triggered, dataOutValid}, 0);
      chk(exp_q.size() == 0, "words_missing", exp_q.size(), 0);
   endtask

   initial begin
      tick();
      tick();
      tick();
      chk({dataOut, dataOutValid, busy, triggered, done} == '0, "reset_outputs",
          int'({dataOut, dataOutValid, busy, triggered, done}), 0);
      reset = 1'b0;
      tick();
      capture(4, 20, 30, 0, 1, 0, -1);
      chk(first_word == 9, "a_first", first_word, 9);
      chk(last_word == 24, "a_last", last_word, 24);
      chk(n_xfer == 16, "a_count", n_xfer, 16);
      chk(last_cyc - first_cyc == 15, "a_back_to_back", last_cyc - first_cyc, 15);
      capture(2, 5, 12, 0, 1, 0, -1);
      chk(n_xfer == 8, "b_count", n_xfer, 8);
      chk(first_word == 0, "b_first", first_word, 0);
      chk(last_word == 7, "b_last", last_word, 7);
      capture(0, 20, 30, 0, 1, 0, -1);
      chk(first_word == 5, "c_first", first_word, 5);
      chk(last_word == 20, "c_last", last_word, 20);
      capture(4, 20, 30, 100, 1, 1, -1);
      chk(n_xfer == 16, "d_count", n_xfer, 16);
      capture(3, 10, 20, 50, 3, 1, -1);
      chk(first_word == 50, "e_first", first_word, 50);
      chk(last_word == 63, "e_last", last_word, 63);
      chk(n_xfer == 14, "e_count", n_xfer, 14);
      capture(4, 20, 25, 0, 1, 0, 3);
      capture(1, 2, 6, 200, 1, 0, -1);
      chk(n_xfer == 4, "f_count", n_xfer, 4);
      chk(first_word == 200, "f_first", first_word, 200);
      rdy_mode = 0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      postCount = 4'd10;
      for (int k = 0; k < 8; k++) begin
         validIn = 1'b1;
         dataIn = 8'(k);
         run = (k == 5);
         tick();
      end
      validIn = 1'b0;
      run = 1'b0;
      chk(triggered && busy, "g_in_post", {triggered, busy}, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk({dataOut, dataOutValid, busy, triggered, done} == '0, "g_reset_outputs",
          int'({dataOut, dataOutValid, busy, triggered, done}), 0);
      for (int t = 0; t < 5; t++)
         tick();
      chk(!busy && !dataOutValid && !triggered, "g_stays_idle", {busy, dataOutValid, triggered}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
